disp_scan_ctrl: RTL and testbench

//  Scheduler for the 8-digit seven-segment display. Two writers (0 = keypad path, 1 = system path)

---
 rtl/disp_scan_ctrl_pkg.sv | 26 ++
 rtl/disp_scan_ctrl_if.sv | 13 +
 rtl/disp_scan_ctrl_seg7_decode.sv | 17 +
 rtl/disp_scan_ctrl.sv | 171 +++++++++++++++++
 tb/tb_disp_scan_ctrl.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/disp_scan_ctrl_pkg.sv
// Shared constants, scan state type and segment table for the display scan controller.
package disp_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int IDX_W      = 3;

    // Code that blanks a digit; 10-14 are illegal and never enter the store.
    localparam logic [3:0] DIG_BLANK = 4'hF;

    typedef enum logic {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } scan_state_t;

    // Active-low {g,f,e,d,c,b,a} patterns for digits 0-9.
    localparam logic [6:0] SEG_LUT [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    // A code may be stored if it is a decimal digit or the blank code.
    function automatic logic dig_legal(input logic [3:0] dig);
        return (dig <= 4'd9) || (dig == DIG_BLANK);
    endfunction

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Two-requester write port into the digit store (valid/ready per requester).
interface disp_scan_ctrl_if;
    import disp_pkg::*;

    logic [1:0]            req_valid;
    logic [1:0][IDX_W-1:0] req_pos;
    logic [1:0][3:0]       req_dig;
    logic [1:0]            req_ready;

    modport master (output req_valid, req_pos, req_dig, input req_ready);
    modport slave  (input req_valid, req_pos, req_dig, output req_ready);

endinterface

// File: rtl/disp_scan_ctrl_seg7_decode.sv
// Combinational digit-code to active-low seven-segment decoder; non-digit codes go dark.
module seg7_decode
    import disp_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg_n
);

    // Table lookup for 0-9, everything else (blank code included) lights nothing.
    always_comb begin
        seg_n = 7'h7F;
        if (code <= 4'd9) begin
            seg_n = SEG_LUT[code];
        end
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Eight-digit display scheduler: round-robin write arbiter, digit store, scan FSM
// and a two-stage registered output path (store read, then decode) driving the pins.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 2
)(
    input  logic                 clock,
    input  logic                 reset,
    disp_scan_ctrl_if.slave      wr,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic [6:0]           seg_n,
    output logic                 dp_n,
    output logic [IDX_W-1:0]     scan_idx,
    output logic                 wr_err
);

    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    // Arbiter state: rr_ptr_reg names the requester preferred when both are valid.
    logic             rr_ptr_reg;
    logic [1:0]       grant;
    logic             wr_fire;
    logic             wr_sel;
    logic [IDX_W-1:0] wr_pos;
    logic [3:0]       wr_dig;
    logic             wr_ok;
    logic             wr_err_reg;

    logic [3:0]       store_reg [NUM_DIGITS];

    scan_state_t      state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [IDX_W-1:0] idx_reg;

    // Pipeline stage 1: registered store read plus the scan position it belongs to.
    logic             show_p_reg;
    logic [IDX_W-1:0] idx_p_reg;
    logic [3:0]       code_p_reg;
    logic [6:0]       seg_dec;

    // Pipeline stage 2: pin registers.
    logic [NUM_DIGITS-1:0] an_n_reg;
    logic [6:0]            seg_n_reg;
    logic                  dp_n_reg;
    logic [IDX_W-1:0]      scan_idx_reg;

    // Grant a lone requester outright; on contention grant the preferred one.
    always_comb begin
        grant    = 2'b00;
        grant[0] = wr.req_valid[0] & (~wr.req_valid[1] | ~rr_ptr_reg);
        grant[1] = wr.req_valid[1] & (~wr.req_valid[0] |  rr_ptr_reg);
    end

    assign wr.req_ready = grant;
    assign wr_fire      = |grant;
    assign wr_sel       = grant[1];
    assign wr_pos       = wr.req_pos[wr_sel];
    assign wr_dig       = wr.req_dig[wr_sel];
    assign wr_ok        = dig_legal(wr_dig);

    // Pointer moves to the other requester only when a transfer actually happens.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr_reg <= 1'b0;
            wr_err_reg <= 1'b0;
        end else begin
            if (wr_fire) begin
                rr_ptr_reg <= ~wr_sel;
            end
            wr_err_reg <= wr_fire & ~wr_ok;
        end
    end

    // Digit store: legal codes overwrite the addressed digit, illegal ones are dropped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                store_reg[i] <= 4'd0;
            end
        end else if (wr_fire && wr_ok) begin
            store_reg[wr_pos] <= wr_dig;
        end
    end

    // Scan FSM: hold each digit SCAN_DIV cycles, then an optional dark guard, then advance.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= SHOW;
            cnt_reg   <= '0;
            idx_reg   <= '0;
        end else begin
            case (state_reg)
                SHOW: begin
                    if (cnt_reg == CNT_W'(SCAN_DIV - 1)) begin
                        cnt_reg <= '0;
                        if (BLANK_CYCLES == 0) begin
                            idx_reg <= idx_reg + 1'b1;
                        end else begin
                            state_reg <= BLANK;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                BLANK: begin
                    if (cnt_reg == CNT_W'(BLANK_CYCLES - 1)) begin
                        cnt_reg   <= '0;
                        idx_reg   <= idx_reg + 1'b1;
                        state_reg <= SHOW;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= SHOW;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    // Stage 1: read the lit digit from the store alongside its scan position.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            show_p_reg <= 1'b0;
            idx_p_reg  <= '0;
            code_p_reg <= 4'd0;
        end else begin
            show_p_reg <= (state_reg == SHOW);
            idx_p_reg  <= idx_reg;
            code_p_reg <= store_reg[idx_reg];
        end
    end

    seg7_decode u_decode (
        .code  (code_p_reg),
        .seg_n (seg_dec)
    );

    // Stage 2: pin registers; dark whenever the slot is a guard slot.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            an_n_reg     <= '1;
            seg_n_reg    <= 7'h7F;
            dp_n_reg     <= 1'b1;
            scan_idx_reg <= '0;
        end else begin
            scan_idx_reg <= idx_p_reg;
            if (show_p_reg) begin
                an_n_reg  <= ~(NUM_DIGITS'(1) << idx_p_reg);
                seg_n_reg <= seg_dec;
                dp_n_reg  <= ~dp_mask[idx_p_reg];
            end else begin
                an_n_reg  <= '1;
                seg_n_reg <= 7'h7F;
                dp_n_reg  <= 1'b1;
            end
        end
    end

    assign an_n     = an_n_reg;
    assign seg_n    = seg_n_reg;
    assign dp_n     = dp_n_reg;
    assign scan_idx = scan_idx_reg;
    assign wr_err   = wr_err_reg;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with SCAN_DIV=4, BLANK_CYCLES=1 (5-cycle digit period).
module tb_disp_scan_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] dp_mask = 8'h00;
    logic [7:0] an_n;
    logic [6:0] seg_n;
    logic       dp_n;
    logic [2:0] scan_idx;
    logic       wr_err;

    disp_scan_ctrl_if wr();

    disp_scan_ctrl #(.SCAN_DIV(4), .BLANK_CYCLES(1)) dut (
        .clock    (clock),
        .reset    (reset),
        .wr       (wr),
        .dp_mask  (dp_mask),
        .an_n     (an_n),
        .seg_n    (seg_n),
        .dp_n     (dp_n),
        .scan_idx (scan_idx),
        .wr_err   (wr_err)
    );

    always #5 clock = ~clock;

    // Cycles since reset release; outputs appear two edges after the scan state.
    int k = 0;
    always @(posedge clock or negedge reset) begin
        if (!reset) k <= 0;
        else        k <= k + 1;
    end

    typedef struct {
        logic [1:0] valid;
        logic [2:0] pos0;
        logic [3:0] dig0;
        logic [2:0] pos1;
        logic [3:0] dig1;
        logic [1:0] exp_ready;
        logic       exp_err;
    } vec_t;

    vec_t       vecs [10];
    logic [3:0] m_store [8];
    logic [6:0] lut [10];
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (k=%0d): got %0h required %0h", name, k, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Expected pins for the current cycle from the cycle count, model store and dp_mask.
    task automatic check_disp();
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic [2:0] e_idx;
        int j, slot, ph;
        e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_idx = 3'd0;
        if (k >= 2) begin
            j    = k - 2;
            slot = (j / 5) % 8;
            ph   = j % 5;
            e_idx = slot[2:0];
            if (ph != 4) begin
                e_an  = ~(8'h01 << slot);
                e_seg = (m_store[slot] == 4'hF) ? 7'h7F : lut[m_store[slot]];
                e_dp  = ~dp_mask[slot];
            end
        end
        check("an_n", an_n, e_an);
        check("seg_n", seg_n, e_seg);
        check("dp_n", dp_n, e_dp);
        check("scan_idx", scan_idx, e_idx);
    endtask

    task automatic scan_check(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            tick();
            check_disp();
        end
    endtask

    task automatic apply_vec(input int i);
        logic [3:0] d;
        logic [2:0] p;
        wr.req_valid  = vecs[i].valid;
        wr.req_pos[0] = vecs[i].pos0;
        wr.req_dig[0] = vecs[i].dig0;
        wr.req_pos[1] = vecs[i].pos1;
        wr.req_dig[1] = vecs[i].dig1;
        #1;
        check($sformatf("req_ready[v%0d]", i), wr.req_ready, vecs[i].exp_ready);
        if (vecs[i].exp_ready != 2'b00) begin
            d = vecs[i].exp_ready[1] ? vecs[i].dig1 : vecs[i].dig0;
            p = vecs[i].exp_ready[1] ? vecs[i].pos1 : vecs[i].pos0;
            if (d <= 4'd9 || d == 4'hF) m_store[p] = d;
        end
        tick();
        check($sformatf("wr_err[v%0d]", i), wr_err, vecs[i].exp_err);
    endtask

    initial begin
        int guard;
        lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        for (int i = 0; i < 8; i++) m_store[i] = 4'd0;
        //          valid  pos0  dig0   pos1  dig1   ready  err
        vecs[0] = '{2'b01, 3'd3, 4'd7,  3'd0, 4'd0,  2'b01, 1'b0};
        vecs[1] = '{2'b10, 3'd0, 4'd0,  3'd0, 4'd9,  2'b10, 1'b0};
        vecs[2] = '{2'b11, 3'd1, 4'd2,  3'd2, 4'd5,  2'b01, 1'b0};
        vecs[3] = '{2'b11, 3'd1, 4'd2,  3'd2, 4'd5,  2'b10, 1'b0};
        vecs[4] = '{2'b11, 3'd1, 4'd2,  3'd2, 4'd5,  2'b01, 1'b0};
        vecs[5] = '{2'b11, 3'd1, 4'd2,  3'd2, 4'd5,  2'b10, 1'b0};
        vecs[6] = '{2'b00, 3'd0, 4'd0,  3'd0, 4'd0,  2'b00, 1'b0};
        vecs[7] = '{2'b01, 3'd0, 4'd12, 3'd0, 4'd0,  2'b01, 1'b1};
        vecs[8] = '{2'b00, 3'd0, 4'd0,  3'd0, 4'd0,  2'b00, 1'b0};
        vecs[9] = '{2'b10, 3'd0, 4'd0,  3'd0, 4'd15, 2'b10, 1'b0};

        wr.req_valid = 2'b00;
        wr.req_pos   = '0;
        wr.req_dig   = '0;

        // Reset state.
        tick();
        tick();
        check_disp();
        check("wr_err@reset", wr_err, 1'b0);
        check("req_ready@idle", wr.req_ready, 2'b00);

        // 1: free-running scan of an all-zero store.
        reset = 1'b1;
        scan_check(42);

        // 2-4: arbitration, store updates and illegal-digit handling.
        for (int i = 0; i < 9; i++) apply_vec(i);
        wr.req_valid = 2'b00;
        tick(); tick(); tick();
        scan_check(40);
        apply_vec(9);
        wr.req_valid = 2'b00;
        tick(); tick(); tick();
        scan_check(40);

        // 5: decimal points on digits 0 and 7.
        dp_mask = 8'h81;
        tick(); tick();
        scan_check(40);

        // 6: reset asserted mid-SHOW of digit 5.
        guard = 0;
        while (((k - 2) % 40) != 26 && guard < 60) begin
            tick();
            guard++;
        end
        check("reach_idx5", ((k - 2) % 40), 26);
        check("an_n@idx5", an_n, 8'hDF);
        #2 reset = 1'b0;
        #1;
        check("an_n@async_rst", an_n, 8'hFF);
        check("seg_n@async_rst", seg_n, 7'h7F);
        check("dp_n@async_rst", dp_n, 1'b1);
        check("scan_idx@async_rst", scan_idx, 3'd0);
        check("wr_err@async_rst", wr_err, 1'b0);
        for (int i = 0; i < 8; i++) m_store[i] = 4'd0;
        @(negedge clock);
        reset = 1'b1;
        wr.req_valid = 2'b11;
        #1;
        check("req_ready@post_rst", wr.req_ready, 2'b01);
        wr.req_valid = 2'b00;
        scan_check(42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
